t01_move_scheduler: RTL and testbench

Sequences all piece-motion requests into one command stream for the Tetris game FSM. Sources are the debounced buttons (right, left, rotate_r, rotate_l), the gravity tick from the 1 Hz/speed-scaled divider, and the soft-drop button. The block edge-detects the inputs, adds auto-repeat for held shifts, and generates soft-drop ticks. It arbitrates pending requests with fixed priority plus a gravity starvation guard, and hands exactly one command at a time to the FSM over a valid/ready handshake.

---
 rtl/t01_move_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_t01_move_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/t01_move_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : t01_move_scheduler                                              |
// | Brief    : Merges button, auto-repeat, soft-drop and gravity requests into |
// |            one valid/ready command stream for the Tetris game FSM.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module t01_move_scheduler #(
  parameter int DAS_DELAY        = 6250000,
  parameter int ARR_PERIOD       = 2500000,
  parameter int SOFT_DROP_PERIOD = 1250000,
  parameter int STARVE_LIMIT     = 16,
  parameter int CMD_GAP          = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       active,
  input  logic       right_i,
  input  logic       left_i,
  input  logic       rotate_r,
  input  logic       rotate_l,
  input  logic       speed_up_i,
  input  logic       gravity_i,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic       busy
);

  // Counter widths; a zero-valued parameter still gets a 1-bit counter.
  localparam int c_DAS_W  = (DAS_DELAY        > 0) ? $clog2(DAS_DELAY + 1)        : 1;
  localparam int c_ARR_W  = (ARR_PERIOD       > 0) ? $clog2(ARR_PERIOD + 1)       : 1;
  localparam int c_SD_W   = (SOFT_DROP_PERIOD > 0) ? $clog2(SOFT_DROP_PERIOD + 1) : 1;
  localparam int c_AGE_W  = (STARVE_LIMIT     > 0) ? $clog2(STARVE_LIMIT + 1)     : 1;
  localparam int c_GAP_W  = (CMD_GAP          > 0) ? $clog2(CMD_GAP + 1)          : 1;

  localparam logic [c_DAS_W-1:0] c_DAS_MAX  = c_DAS_W'(DAS_DELAY);
  localparam logic [c_DAS_W-1:0] c_DAS_LAST = c_DAS_W'(DAS_DELAY - 1);
  localparam logic [c_ARR_W-1:0] c_ARR_LAST = c_ARR_W'(ARR_PERIOD - 1);
  localparam logic [c_SD_W-1:0]  c_SD_LAST  = c_SD_W'(SOFT_DROP_PERIOD - 1);
  localparam logic [c_AGE_W-1:0] c_STARVE   = c_AGE_W'(STARVE_LIMIT);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(CMD_GAP);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

  localparam logic [2:0] c_OP_NONE  = 3'd0;
  localparam logic [2:0] c_OP_RIGHT = 3'd1;
  localparam logic [2:0] c_OP_LEFT  = 3'd2;
  localparam logic [2:0] c_OP_ROT_R = 3'd3;
  localparam logic [2:0] c_OP_ROT_L = 3'd4;
  localparam logic [2:0] c_OP_DROP  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Request vector bit order: 0 RIGHT, 1 LEFT, 2 ROT_R, 3 ROT_L, 4 DROP.
  logic [4:0]         r_hist;
  logic [4:0]         r_pend;
  logic [c_AGE_W-1:0] r_age;
  logic [c_SD_W-1:0]  r_sd;
  logic [c_GAP_W-1:0] r_gap;
  state_t             r_state;

  logic [4:0] w_in;
  logic [4:0] w_rise;
  logic [4:0] w_set;
  logic [4:0] w_grant;
  logic [2:0] w_grant_op;
  logic [1:0] w_lvl;
  logic [1:0] w_opp;
  logic [1:0] w_rep;
  logic       w_sd_fire;

  assign w_in   = {gravity_i, rotate_l, rotate_r, left_i, right_i};
  assign w_rise = w_in & ~r_hist;
  assign w_lvl  = {left_i, right_i};
  assign w_opp  = {right_i, left_i};

  // Opposing same-cycle edges cancel each other; repeats and drop ticks add in.
  assign w_set[0] = (w_rise[0] & ~w_rise[1]) | w_rep[0];
  assign w_set[1] = (w_rise[1] & ~w_rise[0]) | w_rep[1];
  assign w_set[2] =  w_rise[2] & ~w_rise[3];
  assign w_set[3] =  w_rise[3] & ~w_rise[2];
  assign w_set[4] =  w_rise[4] | w_sd_fire;

  // Edge history keeps sampling even while inactive so held buttons never re-fire.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_hist <= '0;
    else       r_hist <= w_in;
  end

  // Per-direction hold timer: DAS_DELAY to the first repeat, then every ARR_PERIOD.
  for (genvar gi = 0; gi < 2; gi++) begin : g_repeat
    logic               w_hold;
    logic [c_DAS_W-1:0] r_das;
    logic [c_ARR_W-1:0] r_arr;

    assign w_hold    = active & w_lvl[gi] & ~w_opp[gi];
    assign w_rep[gi] = w_hold & ((r_das == c_DAS_LAST) |
                                 ((r_das == c_DAS_MAX) & (r_arr == c_ARR_LAST)));

    // Hold counter saturates at the DAS point, then the repeat counter wraps.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_das <= '0;
        r_arr <= '0;
      end else if (!w_hold) begin
        r_das <= '0;
        r_arr <= '0;
      end else if (r_das != c_DAS_MAX) begin
        r_das <= r_das + 1'b1;
      end else if (r_arr == c_ARR_LAST) begin
        r_arr <= '0;
      end else begin
        r_arr <= r_arr + 1'b1;
      end
    end
  end

  assign w_sd_fire = active & speed_up_i & (r_sd == c_SD_LAST);

  // Soft-drop tick counter, wraps after each fire and restarts on release.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                       r_sd <= '0;
    else if (!active || !speed_up_i) r_sd <= '0;
    else if (r_sd == c_SD_LAST)      r_sd <= '0;
    else                             r_sd <= r_sd + 1'b1;
  end

  // Fixed-priority arbiter with a starved DROP jumping the queue; IDLE only.
  always_comb begin
    w_grant    = '0;
    w_grant_op = c_OP_NONE;
    if (active && (r_state == S_IDLE)) begin
      if (r_pend[4] && (r_age == c_STARVE)) begin
        w_grant[4] = 1'b1;
        w_grant_op = c_OP_DROP;
      end else if (r_pend[2]) begin
        w_grant[2] = 1'b1;
        w_grant_op = c_OP_ROT_R;
      end else if (r_pend[3]) begin
        w_grant[3] = 1'b1;
        w_grant_op = c_OP_ROT_L;
      end else if (r_pend[0]) begin
        w_grant[0] = 1'b1;
        w_grant_op = c_OP_RIGHT;
      end else if (r_pend[1]) begin
        w_grant[1] = 1'b1;
        w_grant_op = c_OP_LEFT;
      end else if (r_pend[4]) begin
        w_grant[4] = 1'b1;
        w_grant_op = c_OP_DROP;
      end
    end
  end

  // Pending bits coalesce; a grant clears its bit unless a new request lands the same cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        r_pend <= '0;
    else if (!active) r_pend <= '0;
    else              r_pend <= (r_pend & ~w_grant) | w_set;
  end

  // DROP wait age; the fixed post-command gap is not counted as waiting.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                r_age <= '0;
    else if (!active)         r_age <= '0;
    else if (w_grant[4])      r_age <= '0;
    else if (r_pend[4] && (r_state != S_GAP) && (r_age != c_STARVE))
                              r_age <= r_age + 1'b1;
  end

  // Command handshake FSM with registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= c_OP_NONE;
      busy      <= 1'b0;
    end else if (!active) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= c_OP_NONE;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant != '0) begin
            r_state   <= S_OFFER;
            cmd_valid <= 1'b1;
            cmd_op    <= w_grant_op;
            busy      <= 1'b1;
          end
        end
        S_OFFER: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_op    <= c_OP_NONE;
            if (CMD_GAP == 0) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_GAP;
              r_gap   <= c_GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (r_gap <= c_GAP_ONE) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            busy    <= 1'b0;
          end else begin
            r_gap   <= r_gap - 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_gap     <= '0;
          cmd_valid <= 1'b0;
          cmd_op    <= c_OP_NONE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t01_move_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_t01_move_scheduler                                           |
// | Brief    : Directed scenarios plus random traffic against a cycle model of |
// |            the move scheduler built from hold counts and modulo rules.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_t01_move_scheduler;

  localparam int DAS    = 8;
  localparam int ARR    = 4;
  localparam int SDP    = 5;
  localparam int STARVE = 3;
  localparam int GAP    = 2;
  localparam int PRIO [5] = '{3, 4, 1, 2, 5};

  logic       clk = 1'b0;
  logic       nrst, active, right_i, left_i, rotate_r, rotate_l;
  logic       speed_up_i, gravity_i, cmd_ready;
  logic       cmd_valid, busy;
  logic [2:0] cmd_op;

  t01_move_scheduler #(
    .DAS_DELAY(DAS), .ARR_PERIOD(ARR), .SOFT_DROP_PERIOD(SDP),
    .STARVE_LIMIT(STARVE), .CMD_GAP(GAP)
  ) dut (
    .clk(clk), .nrst(nrst), .active(active), .right_i(right_i), .left_i(left_i),
    .rotate_r(rotate_r), .rotate_l(rotate_l), .speed_up_i(speed_up_i),
    .gravity_i(gravity_i), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_busy   = 0;
  int q_ops [$];
  int q_cyc [$];
  int exp_q [$];

  // Reference model state: st 0 idle, 1 offering, 2 gap.
  bit [5:1] m_pend;
  bit       m_pr, m_pl, m_prr, m_prl, m_pg;
  int       m_hold_r, m_hold_l, m_sd, m_age, m_st, m_op, m_gcnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_pr = 0; m_pl = 0; m_prr = 0; m_prl = 0; m_pg = 0;
    m_hold_r = 0; m_hold_l = 0; m_sd = 0; m_age = 0; m_st = 0; m_op = 0; m_gcnt = 0;
  endtask

  task automatic model_edge();
    bit       r_up, l_up, rr_up, rl_up, g_up;
    bit [5:1] set;
    int       g;
    r_up  = right_i  && !m_pr;
    l_up  = left_i   && !m_pl;
    rr_up = rotate_r && !m_prr;
    rl_up = rotate_l && !m_prl;
    g_up  = gravity_i && !m_pg;
    if (!active) begin
      m_pend = '0; m_hold_r = 0; m_hold_l = 0; m_sd = 0; m_age = 0;
      m_st = 0; m_op = 0; m_gcnt = 0;
    end else begin
      set = '0;
      if (r_up != l_up)   begin set[1] = r_up;  set[2] = l_up;  end
      if (rr_up != rl_up) begin set[3] = rr_up; set[4] = rl_up; end
      m_hold_r = (right_i && !left_i) ? m_hold_r + 1 : 0;
      m_hold_l = (left_i && !right_i) ? m_hold_l + 1 : 0;
      if (m_hold_r >= DAS && (m_hold_r - DAS) % ARR == 0) set[1] = 1;
      if (m_hold_l >= DAS && (m_hold_l - DAS) % ARR == 0) set[2] = 1;
      m_sd = speed_up_i ? m_sd + 1 : 0;
      if (m_sd > 0 && m_sd % SDP == 0) set[5] = 1;
      if (g_up) set[5] = 1;
      g = 0;
      if (m_st == 0 && m_pend != '0) begin
        if (m_pend[5] && m_age == STARVE) g = 5;
        else for (int i = 0; i < 5; i++) if (g == 0 && m_pend[PRIO[i]]) g = PRIO[i];
      end
      if (g == 5) m_age = 0;
      else if (m_pend[5] && m_st != 2) m_age = (m_age < STARVE) ? m_age + 1 : STARVE;
      if (g != 0) m_pend[g] = 1'b0;
      m_pend = m_pend | set;
      case (m_st)
        0: if (g != 0) begin m_st = 1; m_op = g; end
        1: if (cmd_ready) begin
             if (GAP == 0) m_st = 0;
             else begin m_st = 2; m_gcnt = GAP; end
           end
        default: begin m_gcnt--; if (m_gcnt == 0) m_st = 0; end
      endcase
    end
    m_pr = right_i; m_pl = left_i; m_prr = rotate_r; m_prl = rotate_l; m_pg = gravity_i;
  endtask

  // One clock: log accepted commands, advance model, compare outputs.
  task automatic tick();
    if (cmd_valid === 1'b1 && cmd_ready) begin
      q_ops.push_back(int'(cmd_op));
      q_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("cmd_valid", 8'(cmd_valid), 8'(m_st == 1));
    check("cmd_op",    8'(cmd_op),    8'((m_st == 1) ? m_op : 0));
    check("busy",      8'(busy),      8'(m_st != 0));
    if (busy === 1'b1) n_busy++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    q_ops.delete();
    q_cyc.delete();
  endtask

  task automatic check_seq(input string tag, input int e [$]);
    check({tag, "_count"}, 8'(q_ops.size()), 8'(e.size()));
    for (int i = 0; i < e.size() && i < q_ops.size(); i++)
      check({tag, "_op"}, 8'(q_ops[i]), 8'(e[i]));
  endtask

  initial begin
    nrst = 0; active = 1; right_i = 0; left_i = 0; rotate_r = 0; rotate_l = 0;
    speed_up_i = 0; gravity_i = 0; cmd_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 8'(cmd_valid), 8'd0);
    check("reset_op",    8'(cmd_op),    8'd0);
    check("reset_busy",  8'(busy),      8'd0);
    @(negedge clk) nrst = 1;

    // Single press held three cycles: one RIGHT, busy for OFFER + GAP.
    clear_log(); n_busy = 0;
    right_i = 1; ticks(3); right_i = 0; ticks(8);
    exp_q = '{1};
    check_seq("single", exp_q);
    check("single_busy_cycles", 8'(n_busy), 8'd3);

    // Asynchronous reset while a command is being offered.
    cmd_ready = 0; clear_log();
    right_i = 1; tick(); right_i = 0; ticks(2);
    check("pre_reset_valid", 8'(cmd_valid), 8'd1);
    #2 nrst = 0;
    #1;
    check("async_valid", 8'(cmd_valid), 8'd0);
    check("async_op",    8'(cmd_op),    8'd0);
    model_reset();
    @(negedge clk) nrst = 1;
    cmd_ready = 1;
    ticks(8);
    check("post_reset_quiet", 8'(q_ops.size()), 8'd0);

    // Same-cycle rotate_r, right and gravity: priority order, fixed spacing.
    clear_log();
    rotate_r = 1; right_i = 1; gravity_i = 1; tick();
    rotate_r = 0; right_i = 0; gravity_i = 0; ticks(14);
    exp_q = '{3, 1, 5};
    check_seq("priority", exp_q);
    if (q_cyc.size() == 3) begin
      check("priority_gap1", 8'(q_cyc[1] - q_cyc[0]), 8'(GAP + 2));
      check("priority_gap2", 8'(q_cyc[2] - q_cyc[1]), 8'(GAP + 2));
    end

    // Starvation: DROP ages behind a stalled ROT_R and then beats ROT_L.
    clear_log(); cmd_ready = 0;
    rotate_r = 1; gravity_i = 1; tick();
    rotate_r = 0; gravity_i = 0; ticks(5);
    rotate_l = 1; tick(); rotate_l = 0; tick();
    cmd_ready = 1; ticks(14);
    exp_q = '{3, 5, 4};
    check_seq("starve", exp_q);

    // Auto-repeat: left held 20 cycles gives the edge plus holds 8, 12, 16, 20.
    clear_log();
    left_i = 1; ticks(20); left_i = 0; ticks(12);
    exp_q = '{2, 2, 2, 2, 2};
    check_seq("repeat", exp_q);
    if (q_cyc.size() == 5) check("repeat_spacing", 8'(q_cyc[4] - q_cyc[3]), 8'(ARR));

    // Deactivate mid-offer with three requests pending; held buttons stay silent.
    clear_log(); cmd_ready = 0;
    rotate_r = 1; right_i = 1; gravity_i = 1; tick();
    right_i = 0; ticks(2);
    rotate_l = 1; tick();
    active = 0; tick();
    check("deact_valid", 8'(cmd_valid), 8'd0);
    ticks(2);
    active = 1; cmd_ready = 1; ticks(10);
    rotate_r = 0; rotate_l = 0; gravity_i = 0; tick();
    rotate_r = 1; rotate_l = 1; ticks(8);
    rotate_r = 0; rotate_l = 0; ticks(2);
    check("deact_quiet", 8'(q_ops.size()), 8'd0);

    // Soft drop: held speed_up produces DROPs at its period.
    clear_log();
    speed_up_i = 1; ticks(16); speed_up_i = 0; ticks(8);
    exp_q = '{5, 5, 5};
    check_seq("softdrop", exp_q);

    // Random traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(11) == 0) right_i    = ~right_i;
      if ($urandom_range(11) == 0) left_i     = ~left_i;
      if ($urandom_range(5)  == 0) rotate_r   = ~rotate_r;
      if ($urandom_range(5)  == 0) rotate_l   = ~rotate_l;
      if ($urandom_range(9)  == 0) speed_up_i = ~speed_up_i;
      if ($urandom_range(4)  == 0) gravity_i  = ~gravity_i;
      if ($urandom_range(63) == 0) active     = ~active;
      cmd_ready = ($urandom_range(3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
